// File: rtl/fetch_unit_pkg.sv
// Constants shared by the instruction-fetch front end.
package fetch_unit_pkg;
  localparam int unsigned PC_STEP  = 4;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam int unsigned INST_W   = 32;
endpackage

// File: rtl/fetch_unit_fifo.sv
// Prefetch queue: synchronous FIFO with clear; clear dominates push and pop.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty & ~i_clear;
  assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_clear;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited requests, stale-response dropping, prefetch queue.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int QW = XLEN + INST_W;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop;

  logic [CW-1:0]   w_count;
  logic            w_full;
  logic            w_empty;
  logic [QW-1:0]   w_head;
  logic [CW:0]     w_inflight;
  logic            w_credit;
  logic            w_req_fire;
  logic            w_push;
  logic            w_pop;
  logic            w_drop_rsp;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_step;

  assign w_step     = XLEN'(PC_STEP);
  assign w_target   = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_inflight = {1'b0, w_count} + {1'b0, r_outstanding};
  assign w_credit   = (w_inflight < (CW+1)'(DEPTH));

  assign imem_req_valid = w_credit & ~redirect_valid & rst;
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid & imem_req_ready;

  assign w_drop_rsp = imem_rsp_valid & (r_drop != '0);
  assign w_push     = imem_rsp_valid & (r_drop == '0) & ~redirect_valid;

  assign inst_valid = ~w_empty & ~redirect_valid;
  assign w_pop      = inst_valid & inst_ready;
  assign inst       = w_empty ? '0 : w_head[INST_W-1:0];
  assign inst_pc    = w_empty ? '0 : w_head[QW-1:INST_W];

  // On redirect every request still in flight becomes stale, minus the one answered this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc    <= w_target;
      r_rsp_pc      <= w_target;
      r_outstanding <= r_outstanding - CW'(imem_rsp_valid);
      r_drop        <= r_outstanding - CW'(imem_rsp_valid);
    end else begin
      if (w_req_fire) r_fetch_pc <= r_fetch_pc + w_step;
      if (w_push)     r_rsp_pc   <= r_rsp_pc + w_step;
      if (w_drop_rsp) r_drop     <= r_drop - CW'(1);
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);
    end
  end

  fetch_fifo #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_queue (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clear (redirect_valid),
    .i_push  (w_push),
    .i_wdata ({r_rsp_pc, imem_rsp_data}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(w_push && w_full && !w_pop));
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle table plus hand sequences against a latency-L memory model.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          t;
  } req_t;

  typedef struct {
    bit          redir;
    logic [31:0] rpc;
    bit          dready;
    bit          eRv;
    logic [31:0] eAddr;
    bit          eIv;
    logic [31:0] ePc;
  } vec_t;

  req_t        pending[$];
  logic [31:0] fireLog[$];
  vec_t        vecs[20];
  int          nVectors = 0;
  int          nMiss = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          randReady = 0;
  int          fireCount = 0;
  int          delivered = 0;
  logic [31:0] expPc = 0;
  logic [31:0] firstPc = 0;
  bit          prevStall = 0;
  logic [31:0] prevAddr = 0;
  bit          sRv;
  logic [31:0] sAddr;
  bit          sIv;
  logic [31:0] sPc;
  logic [31:0] sInst;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] fireAt(input int i);
    if (i < fireLog.size()) return fireLog[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyReset();
    rst = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    inst_ready = 1'b0;
    pending.delete();
    fireLog.delete();
    fireCount = 0;
    delivered = 0;
    expPc = 32'h0;
    prevStall = 0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_valid", imem_req_valid, 0);
    checkOutput("rst_req_addr", imem_req_addr, 32'h0);
    checkOutput("rst_inst_valid", inst_valid, 0);
    checkOutput("rst_inst", inst, 32'h0);
    checkOutput("rst_inst_pc", inst_pc, 32'h0);
    rst = 1'b1;
    cyc = 1;
  endtask

  // One clock: memory model drives its response, outputs are sampled mid-cycle, scoreboard checks pops.
  task automatic applyStimulus(input bit redir, input logic [31:0] rpc, input bit dready);
    bit rspV;
    bit fired;
    rspV = 0;
    if (pending.size() > 0) rspV = (cyc >= pending[0].t + lat);
    imem_rsp_valid = rspV;
    imem_rsp_data = rspV ? memWord(pending[0].addr) : 32'h0;
    imem_req_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    redirect_valid = redir;
    redirect_pc = rpc;
    inst_ready = dready;
    #1;
    sRv = imem_req_valid;
    sAddr = imem_req_addr;
    sIv = inst_valid;
    sPc = inst_pc;
    sInst = inst;
    if (prevStall && !redir) checkOutput("addr_stable", sAddr, prevAddr);
    prevStall = sRv && !imem_req_ready;
    prevAddr = sAddr;
    if (sIv && dready) begin
      checkOutput("sb_pc", sPc, expPc);
      checkOutput("sb_data", sInst, memWord(expPc));
      if (delivered == 0) firstPc = sPc;
      delivered++;
      expPc = expPc + 32'd4;
    end
    if (redir) expPc = rpc & ~32'h3;
    fired = sRv && imem_req_ready;
    @(posedge clk);
    if (rspV) void'(pending.pop_front());
    if (fired) begin
      pending.push_back('{sAddr, cyc});
      fireLog.push_back(sAddr);
      fireCount++;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //            redir rpc           rdy eRv eAddr         eIv ePc
    vecs[0]  = '{0, 32'h0,   1, 1, 32'h000, 0, 32'h000};
    vecs[1]  = '{0, 32'h0,   1, 1, 32'h004, 0, 32'h000};
    vecs[2]  = '{0, 32'h0,   1, 1, 32'h008, 1, 32'h000};
    vecs[3]  = '{0, 32'h0,   1, 1, 32'h00C, 1, 32'h004};
    vecs[4]  = '{0, 32'h0,   1, 1, 32'h010, 1, 32'h008};
    vecs[5]  = '{1, 32'h203, 1, 0, 32'h000, 0, 32'h000};
    vecs[6]  = '{0, 32'h0,   1, 1, 32'h200, 0, 32'h000};
    vecs[7]  = '{0, 32'h0,   1, 1, 32'h204, 0, 32'h000};
    vecs[8]  = '{0, 32'h0,   1, 1, 32'h208, 1, 32'h200};
    vecs[9]  = '{0, 32'h0,   1, 1, 32'h20C, 1, 32'h204};
    vecs[10] = '{0, 32'h0,   0, 1, 32'h210, 1, 32'h208};
    vecs[11] = '{0, 32'h0,   0, 1, 32'h214, 1, 32'h208};
    vecs[12] = '{0, 32'h0,   0, 0, 32'h000, 1, 32'h208};
    vecs[13] = '{0, 32'h0,   0, 0, 32'h000, 1, 32'h208};
    vecs[14] = '{0, 32'h0,   1, 0, 32'h000, 1, 32'h208};
    vecs[15] = '{0, 32'h0,   1, 1, 32'h218, 1, 32'h20C};
    vecs[16] = '{0, 32'h0,   1, 1, 32'h21C, 1, 32'h210};
    vecs[17] = '{0, 32'h0,   1, 1, 32'h220, 1, 32'h214};
    vecs[18] = '{0, 32'h0,   1, 1, 32'h224, 1, 32'h218};
    vecs[19] = '{0, 32'h0,   1, 1, 32'h228, 1, 32'h21C};

    rst = 1'b0;
    @(negedge clk);

    // Table: L=1 stream, redirect to an unaligned target, then a decode stall.
    lat = 1;
    applyReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].redir, vecs[i].rpc, vecs[i].dready);
      checkOutput($sformatf("tbl%0d_req_valid", i), sRv, vecs[i].eRv);
      if (vecs[i].eRv) checkOutput($sformatf("tbl%0d_req_addr", i), sAddr, vecs[i].eAddr);
      checkOutput($sformatf("tbl%0d_inst_valid", i), sIv, vecs[i].eIv);
      if (vecs[i].eIv) checkOutput($sformatf("tbl%0d_inst_pc", i), sPc, vecs[i].ePc);
    end

    // Stall decode from reset: credit caps requests at DEPTH, then drain back-to-back.
    lat = 1;
    applyReset();
    for (int i = 0; i < 10; i++) applyStimulus(0, 32'h0, 0);
    checkOutput("stall_fire_count", fireCount, 4);
    checkOutput("stall_req_low", sRv, 0);
    fireLog.delete();
    for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, 1);
    checkOutput("drain_count", delivered, 4);
    checkOutput("resume_addr", fireAt(0), 32'h10);

    // L=3, redirect with two requests in flight: both stale words must vanish.
    lat = 3;
    applyReset();
    applyStimulus(0, 32'h0, 1);
    applyStimulus(0, 32'h0, 1);
    applyStimulus(1, 32'h100, 1);
    checkOutput("redir3_req_valid", sRv, 0);
    delivered = 0;
    for (int i = 0; i < 12; i++) applyStimulus(0, 32'h0, 1);
    checkOutput("redir3_first_pc", firstPc, 32'h100);
    checkOutput("redir3_progress", delivered >= 3, 1);

    // L=2, redirect landing on a response with decode ready: pop ignored, one stale word remains.
    lat = 2;
    applyReset();
    for (int i = 0; i < 6; i++) applyStimulus(0, 32'h0, 1);
    applyStimulus(1, 32'h300, 1);
    checkOutput("redir_rsp_inst_valid", sIv, 0);
    checkOutput("redir_rsp_req_valid", sRv, 0);
    delivered = 0;
    for (int i = 0; i < 10; i++) applyStimulus(0, 32'h0, 1);
    checkOutput("redir_rsp_first_pc", firstPc, 32'h300);
    checkOutput("redir_rsp_progress", delivered >= 5, 1);

    // Address wrap at the top of the 32-bit space.
    lat = 1;
    applyReset();
    for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 1);
    applyStimulus(1, 32'hFFFF_FFF8, 1);
    fireLog.delete();
    for (int i = 0; i < 6; i++) applyStimulus(0, 32'h0, 1);
    checkOutput("wrap_addr0", fireAt(0), 32'hFFFF_FFF8);
    checkOutput("wrap_addr1", fireAt(1), 32'hFFFF_FFFC);
    checkOutput("wrap_addr2", fireAt(2), 32'h0000_0000);

    // Reset mid-stream with three requests outstanding.
    lat = 3;
    applyReset();
    for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, 1);
    rst = 1'b0;
    #1;
    checkOutput("midrst_req_valid", imem_req_valid, 0);
    checkOutput("midrst_req_addr", imem_req_addr, 32'h0);
    checkOutput("midrst_inst_valid", inst_valid, 0);
    checkOutput("midrst_inst", inst, 32'h0);
    checkOutput("midrst_inst_pc", inst_pc, 32'h0);
    applyReset();
    applyStimulus(0, 32'h0, 1);
    checkOutput("midrst_first_req_valid", sRv, 1);
    checkOutput("midrst_first_req_addr", sAddr, 32'h0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 32'h0, 1);
    checkOutput("midrst_first_pc", firstPc, 32'h0);
    checkOutput("midrst_progress", delivered >= 3, 1);

    // Random memory backpressure and decode stalls; address must hold while a request waits.
    lat = 2;
    randReady = 1;
    applyReset();
    for (int i = 0; i < 80; i++) applyStimulus(0, 32'h0, 1'($urandom_range(0, 1)));
    checkOutput("random_progress", delivered >= 10, 1);
    randReady = 0;

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
    $finish;
  end
endmodule
